// File: rtl/reset_seq_pkg.sv
// Shared state encoding and cause-vector layout for reset_sequencer.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_HOLD  = 2'd2
   } seq_state_t;

   localparam int DEF_NUM_SRC = 4;
   localparam int CAUSE_W     = DEF_NUM_SRC + 2;

   // Cause layout: sources in the low bits, then power-on, then watchdog.
   function automatic int cause_w(input int num_src);
      return num_src + 2;
   endfunction

   function automatic int cause_por(input int num_src);
      return num_src;
   endfunction

   function automatic int cause_wdog(input int num_src);
      return num_src + 1;
   endfunction

endpackage

// File: rtl/reset_seq_delay_line.sv
// seq_delay_line: DEPTH-deep shift register, asynchronously preset to 1;
// a depth of 0 is a plain wire. any_set reports whether any stage is high.
module seq_delay_line #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q,
   output logic any_set
);

   generate
      if (DEPTH == 0) begin : g_pass
         assign q       = d;
         assign any_set = 1'b0;
      end else begin : g_shift
         logic [DEPTH-1:0] r_stage;

         if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) r_stage <= '1;
               else          r_stage <= d;
            end
         end else begin : g_many
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) r_stage <= '1;
               else          r_stage <= {r_stage[DEPTH-2:0], d};
            end
         end

         assign q       = r_stage[DEPTH-1];
         assign any_set = |r_stage;
      end
   endgenerate

endmodule

// File: rtl/reset_sequencer.sv
// Merges NUM_SRC asynchronous reset requests into one stretched, delayed
// machine reset with sticky cause bits. Optional watchdog: RESET_SEQ_WATCHDOG_EN.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_SRC      = DEF_NUM_SRC,
   parameter int PULSE_CYCLES = 16,
   parameter int DELAY_CYCLES = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int WDOG_CYCLES  = 50000000
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NUM_SRC-1:0]   src_in,
   input  logic [NUM_SRC-1:0]   src_mask,
   input  logic [NUM_SRC-1:0]   src_level,
   input  logic                 cause_clr,
   input  logic                 wdog_kick,
   output logic                 sys_reset_pre,
   output logic                 sys_reset_out,
   output logic                 busy,
   output logic [NUM_SRC+1:0]   cause
);

   localparam int CW     = cause_w(NUM_SRC);
   localparam int POR_I  = cause_por(NUM_SRC);
   localparam int WDOG_I = cause_wdog(NUM_SRC);
   localparam int CNT_W  = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);

   seq_state_t        r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [CW-1:0]     r_cause, w_set;
   logic [NUM_SRC-1:0] w_sy, r_prev, w_trig;
   logic              w_act, w_lvl, w_wdog_fire, w_dl_any;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_sync
         logic [SYNC_STAGES-1:0] r_sync;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) r_sync <= '0;
            else          r_sync <= {r_sync[SYNC_STAGES-2:0], src_in[gi]};
         end
         assign w_sy[gi] = r_sync[SYNC_STAGES-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_prev <= '0;
      else          r_prev <= w_sy;
   end

   // Level sources trigger on the synchronised level, edge sources on a rise.
   assign w_trig = ~src_mask & ((src_level & w_sy) | (~src_level & w_sy & ~r_prev));
   assign w_act  = |w_trig;
   assign w_lvl  = |(~src_mask & src_level & w_sy);

`ifdef RESET_SEQ_WATCHDOG_EN
   localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WDOG_CYCLES - 1);
   logic [WD_W-1:0] r_wdog;

   // Held at the reload value outside IDLE, so every IDLE entry starts fresh.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                              r_wdog <= WD_LOAD;
      else if (r_state != ST_IDLE || wdog_kick)  r_wdog <= WD_LOAD;
      else if (r_wdog != '0)                     r_wdog <= r_wdog - 1'b1;
   end

   assign w_wdog_fire = (r_state == ST_IDLE) && !wdog_kick && (r_wdog == '0);
`else
   logic w_unused_wdog;
   assign w_unused_wdog = wdog_kick & (WDOG_CYCLES > 0);
   assign w_wdog_fire   = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_PULSE;
         r_cnt   <= CNT_LOAD;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_act || w_wdog_fire) begin
               w_state_nxt = ST_PULSE;
               w_cnt_nxt   = CNT_LOAD;
            end
         end
         ST_PULSE: begin
            // A trigger on the terminal count reloads rather than exits.
            if (w_act) begin
               w_cnt_nxt = CNT_LOAD;
            end else if (r_cnt == '0) begin
               w_state_nxt = w_lvl ? ST_HOLD : ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         ST_HOLD: begin
            if (!w_lvl) begin
               w_state_nxt = ST_PULSE;
               w_cnt_nxt   = CNT_LOAD;
            end
         end
         default: begin
            w_state_nxt = ST_PULSE;
            w_cnt_nxt   = CNT_LOAD;
         end
      endcase
   end

   always_comb begin
      sys_reset_pre = (r_state != ST_IDLE);
      busy          = sys_reset_pre | w_dl_any;
   end

   seq_delay_line #(.DEPTH(DELAY_CYCLES)) u_delay (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (sys_reset_pre),
      .q       (sys_reset_out),
      .any_set (w_dl_any)
   );

   always_comb begin
      w_set                = '0;
      w_set[NUM_SRC-1:0]   = w_trig;
      w_set[WDOG_I]        = w_wdog_fire;
   end

   // New cause bits win over a same-cycle clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cause        <= '0;
         r_cause[POR_I] <= 1'b1;
      end else begin
         r_cause <= (cause_clr ? '0 : r_cause) | w_set;
      end
   end

   assign cause = r_cause;

endmodule
